// File: rtl/alu_operand_stage.sv
// Operand-supply and write-back stage for the ALU32 combinational ALU: 32-entry regfile, EX stage,
// write-back, retire counter. Define ALU_OPSTAGE_FWD_EN for EX-to-issue forwarding.
module alu_operand_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CTR_W  = 4,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [CTR_W-1:0]  in_aluctr,
    input  logic              stall,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] alu_dataa,
    output logic [DATA_W-1:0] alu_datab,
    output logic [CTR_W-1:0]  alu_aluctr,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              ex_valid,
    output logic              zero_flag,
    output logic [CNT_W-1:0]  retire_cnt,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    localparam int unsigned NRegs = 2 ** ADDR_W;

    logic [DATA_W-1:0] rf_q [NRegs];
    logic              ex_valid_q, ex_valid_d;
    logic [ADDR_W-1:0] ex_rd_q, ex_rd_d;
    logic [DATA_W-1:0] dataa_q, dataa_d, datab_q, datab_d;
    logic [CTR_W-1:0]  aluctr_q, aluctr_d;
    logic              zero_q, zero_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              retire, wb_en, ld_wr, accept;
    logic [DATA_W-1:0] rf_a, rf_b, op_a, op_b;

    always_comb begin
        retire = ex_valid_q & ~stall;
        wb_en  = retire & (ex_rd_q != '0);
        // Write-back wins over an external load to the same register.
        ld_wr  = ld_en & (ld_addr != '0) & ~(wb_en & (ld_addr == ex_rd_q));
        rf_a   = (in_rs1 == '0) ? '0 : rf_q[in_rs1];
        rf_b   = (in_rs2 == '0) ? '0 : rf_q[in_rs2];
`ifdef ALU_OPSTAGE_FWD_EN
        op_a     = (wb_en && (ex_rd_q == in_rs1)) ? alu_result : rf_a;
        op_b     = (wb_en && (ex_rd_q == in_rs2)) ? alu_result : rf_b;
        in_ready = ~ex_valid_q | ~stall;
`else
        op_a     = rf_a;
        op_b     = rf_b;
        // Without forwarding, hold issue for one bubble until the producer has written back.
        in_ready = (~ex_valid_q | ~stall) &
                   ~(ex_valid_q & (ex_rd_q != '0) & ((in_rs1 == ex_rd_q) | (in_rs2 == ex_rd_q)));
`endif
        accept = in_valid & in_ready;
    end

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_rd_d    = ex_rd_q;
        dataa_d    = dataa_q;
        datab_d    = datab_q;
        aluctr_d   = aluctr_q;
        zero_d     = zero_q;
        cnt_d      = cnt_q;
        if (accept) begin
            ex_valid_d = 1'b1;
            ex_rd_d    = in_rd;
            dataa_d    = op_a;
            datab_d    = op_b;
            aluctr_d   = in_aluctr;
        end else if (retire) begin
            ex_valid_d = 1'b0;
        end
        if (retire) begin
            zero_d = alu_zero;
            cnt_d  = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NRegs; i++) rf_q[i] <= '0;
            ex_valid_q <= 1'b0;
            ex_rd_q    <= '0;
            dataa_q    <= '0;
            datab_q    <= '0;
            aluctr_q   <= '0;
            zero_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            if (ld_wr) rf_q[ld_addr] <= ld_data;
            if (wb_en) rf_q[ex_rd_q] <= alu_result;
            ex_valid_q <= ex_valid_d;
            ex_rd_q    <= ex_rd_d;
            dataa_q    <= dataa_d;
            datab_q    <= datab_d;
            aluctr_q   <= aluctr_d;
            zero_q     <= zero_d;
            cnt_q      <= cnt_d;
        end
    end

    assign alu_dataa  = dataa_q;
    assign alu_datab  = datab_q;
    assign alu_aluctr = aluctr_q;
    assign ex_valid   = ex_valid_q;
    assign zero_flag  = zero_q;
    assign retire_cnt = cnt_q;
    assign dbg_data   = (dbg_addr == '0) ? '0 : rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: directed issues push expected EX operands, a monitor
// checks them at each retire; register/flag/counter state is checked directly.
module tb_alu_operand_stage;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, stall, ld_en, ex_valid, zero_flag, alu_zero;
    logic [4:0]  in_rs1, in_rs2, in_rd, ld_addr, dbg_addr;
    logic [3:0]  in_aluctr, alu_aluctr;
    logic [31:0] ld_data, alu_dataa, alu_datab, alu_result, dbg_data, retire_cnt;

    int checks = 0;
    int errors = 0;
    logic [67:0] exp_q [$];
    int unsigned exp_cnt;

    always #5 clk = ~clk;

    // ALU32 model: 0000 add, 0001 sub, 0010 and, 0011 or, otherwise xor.
    always_comb begin
        case (alu_aluctr)
            4'b0000: alu_result = alu_dataa + alu_datab;
            4'b0001: alu_result = alu_dataa - alu_datab;
            4'b0010: alu_result = alu_dataa & alu_datab;
            4'b0011: alu_result = alu_dataa | alu_datab;
            default: alu_result = alu_dataa ^ alu_datab;
        endcase
        alu_zero = (alu_result == 32'h0);
    end

    alu_operand_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_rd(in_rd), .in_aluctr(in_aluctr), .stall(stall), .ld_en(ld_en),
        .ld_addr(ld_addr), .ld_data(ld_data), .alu_dataa(alu_dataa), .alu_datab(alu_datab),
        .alu_aluctr(alu_aluctr), .alu_result(alu_result), .alu_zero(alu_zero),
        .ex_valid(ex_valid), .zero_flag(zero_flag), .retire_cnt(retire_cnt),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every retiring EX instruction must match the oldest expected issue.
    always @(negedge clk) begin
        if (!rst && ex_valid && !stall) begin
            if (exp_q.size() == 0) check("unexpected_retire", 68'd1, 68'd0);
            else check("ex_operands", {alu_dataa, alu_datab, alu_aluctr}, exp_q.pop_front());
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [4:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic reg_is(input string name, input logic [4:0] a, input logic [31:0] exp);
        dbg_addr = a;
        #1;
        check(name, {36'h0, dbg_data}, {36'h0, exp});
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [3:0] ctr, input logic [31:0] ea, input logic [31:0] eb,
                         input bit push, output int waits);
        in_valid = 1'b1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_aluctr = ctr;
        waits = 0;
        @(negedge clk);
        while (!in_ready && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) check("issue_timeout", 68'd1, 68'd0);
        if (push) exp_q.push_back({ea, eb, ctr});
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    int w;

    initial begin
        rst = 1'b1; in_valid = 1'b0; stall = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        in_aluctr = '0; dbg_addr = '0;
        ld_en = 1'b1; ld_addr = 5'd1; ld_data = 32'hDEADBEEF;
        idle(2);
        rst = 1'b0; ld_en = 1'b0;
        exp_cnt = 0;
        for (int i = 0; i < 32; i++) reg_is("reset_reg", 5'(i), 32'h0);
        check("reset_cnt", {36'h0, retire_cnt}, 68'd0);
        check("reset_flags", {66'h0, ex_valid, zero_flag}, 68'd0);
        check("reset_ready", {67'h0, in_ready}, 68'd1);

        // 5 + (-5) = 0
        load(5'd1, 32'h00000005);
        load(5'd2, 32'hFFFFFFFB);
        issue(5'd1, 5'd2, 5'd3, 4'b0000, 32'h5, 32'hFFFFFFFB, 1'b1, w);
        idle(2); exp_cnt++;
        reg_is("add_zero_r3", 5'd3, 32'h0);
        check("add_zero_flag", {67'h0, zero_flag}, 68'd1);
        check("add_zero_cnt", {36'h0, retire_cnt}, {36'h0, exp_cnt});

        // Back-to-back dependent pair
        load(5'd1, 32'd7);
        load(5'd2, 32'd1);
        issue(5'd1, 5'd2, 5'd3, 4'b0000, 32'd7, 32'd1, 1'b1, w);
        issue(5'd3, 5'd1, 5'd4, 4'b0000, 32'd8, 32'd7, 1'b1, w);
`ifdef ALU_OPSTAGE_FWD_EN
        check("b2b_wait_cycles", 68'(w), 68'd0);
`else
        check("b2b_wait_cycles", 68'(w), 68'd1);
`endif
        idle(2); exp_cnt += 2;
        reg_is("b2b_r3", 5'd3, 32'd8);
        reg_is("b2b_r4", 5'd4, 32'd15);
        check("b2b_zero_flag", {67'h0, zero_flag}, 68'd0);
        check("b2b_cnt", {36'h0, retire_cnt}, {36'h0, exp_cnt});

        // Stall 3 cycles on r5 = 7 - 1
        issue(5'd1, 5'd2, 5'd5, 4'b0001, 32'd7, 32'd1, 1'b1, w);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_hold", {alu_dataa, alu_datab, alu_aluctr}, {32'd7, 32'd1, 4'b0001});
            check("stall_ready_valid", {66'h0, in_ready, ex_valid}, 68'b01);
            check("stall_cnt", {36'h0, retire_cnt}, {36'h0, exp_cnt});
        end
        @(posedge clk); #1;
        stall = 1'b0;
        idle(3); exp_cnt++;
        reg_is("stall_r5", 5'd5, 32'd6);
        check("stall_cnt_once", {36'h0, retire_cnt}, {36'h0, exp_cnt});

        // Write to r0 is dropped and never forwarded
        load(5'd1, 32'h80000000);
        load(5'd2, 32'h0);
        issue(5'd1, 5'd2, 5'd0, 4'b0000, 32'h80000000, 32'h0, 1'b1, w);
        issue(5'd0, 5'd1, 5'd6, 4'b0000, 32'h0, 32'h80000000, 1'b1, w);
        check("r0_no_bubble", 68'(w), 68'd0);
        idle(2); exp_cnt += 2;
        reg_is("r0_reads_zero", 5'd0, 32'h0);
        reg_is("r0_fwd_r6", 5'd6, 32'h80000000);
        check("r0_cnt", {36'h0, retire_cnt}, {36'h0, exp_cnt});

        // Same-edge load and write-back to r5: write-back wins
        issue(5'd1, 5'd1, 5'd5, 4'b0010, 32'h80000000, 32'h80000000, 1'b1, w);
        load(5'd5, 32'h12345678);
        idle(1); exp_cnt++;
        reg_is("wb_beats_ld_r5", 5'd5, 32'h80000000);
        check("wb_beats_ld_cnt", {36'h0, retire_cnt}, {36'h0, exp_cnt});

        // Reset with a live EX instruction: no write-back
        issue(5'd1, 5'd2, 5'd7, 4'b0000, 32'h80000000, 32'h0, 1'b0, w);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(1);
        reg_is("rst_mid_r7", 5'd7, 32'h0);
        reg_is("rst_mid_r1", 5'd1, 32'h0);
        check("rst_mid_cnt", {36'h0, retire_cnt}, 68'd0);
        check("rst_mid_flags", {66'h0, ex_valid, zero_flag}, 68'd0);
        check("rst_mid_outputs", {alu_dataa, alu_datab, alu_aluctr}, 68'd0);
        check("scoreboard_empty", 68'(exp_q.size()), 68'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1);
    end
endmodule
